// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation MV tracker: default geometry,
// candidate step directions and control states.
package me_pkg;

  localparam int DEF_MACRO_DIM  = 16;
  localparam int DEF_SEARCH_DIM = 48;
  localparam int MV_W           = 6;

  typedef enum logic [1:0] {
    DIR_YM   = 2'd0,
    DIR_YP   = 2'd1,
    DIR_XP   = 2'd2,
    DIR_NONE = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/me_pos_counter.sv
// Search-window position tracker: applies a step per candidate and refuses
// any step that would leave 0..RANGE, flagging it instead.
module me_pos_counter
  import me_pkg::*;
#(
  parameter int RANGE = 32,
  parameter int PW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  input  dir_e          dir,
  output logic [PW-1:0] next_x,
  output logic [PW-1:0] next_y,
  output logic          oob
);

  logic [PW-1:0] pos_x_r;
  logic [PW-1:0] pos_y_r;

  // Candidate position for this cycle; an illegal step leaves it unchanged.
  always_comb begin
    next_x = pos_x_r;
    next_y = pos_y_r;
    oob    = 1'b0;
    if (step) begin
      case (dir)
        DIR_YM: begin
          if (pos_y_r == PW'(0)) oob = 1'b1;
          else                   next_y = pos_y_r - PW'(1);
        end
        DIR_YP: begin
          if (pos_y_r == PW'(RANGE)) oob = 1'b1;
          else                       next_y = pos_y_r + PW'(1);
        end
        DIR_XP: begin
          if (pos_x_r == PW'(RANGE)) oob = 1'b1;
          else                       next_x = pos_x_r + PW'(1);
        end
        default: begin
          next_x = pos_x_r;
          next_y = pos_y_r;
        end
      endcase
    end else begin
      oob = 1'b0;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_r <= {PW{1'b0}};
      pos_y_r <= {PW{1'b0}};
    end else if (clear) begin
      pos_x_r <= {PW{1'b0}};
      pos_y_r <= {PW{1'b0}};
    end else if (step) begin
      pos_x_r <= next_x;
      pos_y_r <= next_y;
    end
  end

endmodule

// File: rtl/me_mv_tracker.sv
// Tracks the minimum-SAD candidate of a macroblock search and presents the
// resulting motion vector through a valid/ready handshake.
module me_mv_tracker
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = DEF_MACRO_DIM,
  parameter int SEARCH_DIM = DEF_SEARCH_DIM,
  parameter int SAD_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    readyi,
  input  logic                    cand_valid,
  input  logic [SAD_W-1:0]        cand_sad,
  input  logic [1:0]              cand_dir,
  input  logic                    done,
  output logic                    valido,
  input  logic                    readyo,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  mv_x,
  output logic signed [MV_W-1:0]  mv_y,
  output logic                    err
);

  localparam int RANGE   = SEARCH_DIM - MACRO_DIM;
  localparam int HALF    = RANGE / 2;
  localparam int PW      = $clog2(RANGE + 1);
  localparam int CNT_MAX = (RANGE + 1) * (RANGE + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_r;
  logic               readyi_r;
  logic               valido_r;
  logic [SAD_W-1:0]   best_sad_r;
  logic [MV_W-1:0]    mv_x_r;
  logic [MV_W-1:0]    mv_y_r;
  logic               err_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               clear_s;
  logic               step_s;
  logic               better_s;
  logic [PW-1:0]      next_x_s;
  logic [PW-1:0]      next_y_s;
  logic               oob_s;

  // Restart on start in IDLE, or in SCAN when done is not competing with it.
  always_comb begin
    clear_s  = 1'b0;
    step_s   = 1'b0;
    better_s = 1'b0;
    case (state_r)
      ST_IDLE: clear_s = start;
      ST_SCAN: begin
        if (start && !done) begin
          clear_s = 1'b1;
        end else begin
          step_s = cand_valid;
        end
      end
      default: clear_s = 1'b0;
    endcase
    if (step_s && ((cnt_r == CNT_W'(0)) || (cand_sad < best_sad_r))) begin
      better_s = 1'b1;
    end else begin
      better_s = 1'b0;
    end
  end

  me_pos_counter #(
    .RANGE (RANGE),
    .PW    (PW)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_s),
    .step   (step_s),
    .dir    (dir_e'(cand_dir)),
    .next_x (next_x_s),
    .next_y (next_y_s),
    .oob    (oob_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      readyi_r   <= 1'b1;
      valido_r   <= 1'b0;
      best_sad_r <= {SAD_W{1'b1}};
      mv_x_r     <= {MV_W{1'b0}};
      mv_y_r     <= {MV_W{1'b0}};
      err_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      if (clear_s) begin
        best_sad_r <= {SAD_W{1'b1}};
        mv_x_r     <= {MV_W{1'b0}};
        mv_y_r     <= {MV_W{1'b0}};
        err_r      <= 1'b0;
        cnt_r      <= {CNT_W{1'b0}};
      end else if (step_s) begin
        if (cnt_r != CNT_W'(CNT_MAX)) cnt_r <= cnt_r + CNT_W'(1);
        if (oob_s) err_r <= 1'b1;
        if (better_s) begin
          best_sad_r <= cand_sad;
          mv_x_r     <= MV_W'(next_x_s) - MV_W'(HALF);
          mv_y_r     <= MV_W'(next_y_s) - MV_W'(HALF);
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_SCAN;
            readyi_r <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (done) begin
            state_r  <= ST_HOLD;
            valido_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (valido_r && readyo) begin
            state_r  <= ST_IDLE;
            valido_r <= 1'b0;
            readyi_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          valido_r <= 1'b0;
          readyi_r <= 1'b1;
        end
      endcase
    end
  end

  assign readyi   = readyi_r;
  assign valido   = valido_r;
  assign best_sad = best_sad_r;
  assign mv_x     = mv_x_r;
  assign mv_y     = mv_y_r;
  assign err      = err_r;

endmodule

// File: tb/tb_me_mv_tracker.sv
// Directed bench for me_mv_tracker: per-cycle vector table plus hand-written
// snake scan, HOLD stall and mid-search reset sequences.
module tb_me_mv_tracker;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              readyi;
  logic              cand_valid;
  logic [15:0]       cand_sad;
  logic [1:0]        cand_dir;
  logic              done;
  logic              valido;
  logic              readyo;
  logic [15:0]       best_sad;
  logic signed [5:0] mv_x;
  logic signed [5:0] mv_y;
  logic              err;

  int n_chk = 0;
  int n_err = 0;

  me_mv_tracker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .readyi(readyi),
    .cand_valid(cand_valid), .cand_sad(cand_sad), .cand_dir(cand_dir),
    .done(done), .valido(valido), .readyo(readyo), .best_sad(best_sad),
    .mv_x(mv_x), .mv_y(mv_y), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, cv, sad, dir, dn, rdy;
    int e_val, e_rdyi, e_sad, e_mx, e_my, e_err;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(int st, int cv, int sad, int dir, int dn, int rdy,
                              int ev, int er, int es, int mx, int my, int ee);
    vec_t v;
    v.st = st; v.cv = cv; v.sad = sad; v.dir = dir; v.dn = dn; v.rdy = rdy;
    v.e_val = ev; v.e_rdyi = er; v.e_sad = es; v.e_mx = mx; v.e_my = my; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ev, input int er, input int es,
                            input int mx, input int my, input int ee);
    chk({tag, ".valido"},   int'(valido),       ev);
    chk({tag, ".readyi"},   int'(readyi),       er);
    chk({tag, ".best_sad"}, int'(best_sad),     es);
    chk({tag, ".mv_x"},     int'($signed(mv_x)), mx);
    chk({tag, ".mv_y"},     int'($signed(mv_y)), my);
    chk({tag, ".err"},      int'(err),          ee);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int st, input int cv, input int sad, input int dir,
                       input int dn, input int rdy);
    start      = st[0];
    cand_valid = cv[0];
    cand_sad   = 16'(sad);
    cand_dir   = 2'(dir);
    done       = dn[0];
    readyo     = rdy[0];
  endtask

  initial begin
    // start cv sad dir done rdy | valido readyi best mv_x mv_y err
    vecs[0]  = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[1]  = mk(0,1,100,3,0,0, 0,0,  100,-16,-16,0);
    vecs[2]  = mk(0,0,  0,3,1,0, 1,0,  100,-16,-16,0);
    vecs[3]  = mk(0,0,  0,3,0,1, 0,1,  100,-16,-16,0);
    vecs[4]  = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[5]  = mk(0,1, 50,3,0,0, 0,0,   50,-16,-16,0);
    vecs[6]  = mk(0,1, 50,1,1,0, 1,0,   50,-16,-16,0);
    vecs[7]  = mk(0,0,  0,3,0,1, 0,1,   50,-16,-16,0);
    vecs[8]  = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[9]  = mk(0,1, 30,0,0,0, 0,0,   30,-16,-16,1);
    vecs[10] = mk(0,1, 20,1,0,0, 0,0,   20,-16,-15,1);
    vecs[11] = mk(0,1, 25,2,0,0, 0,0,   20,-16,-15,1);
    vecs[12] = mk(0,1,  5,2,1,0, 1,0,    5,-14,-15,1);
    vecs[13] = mk(1,1,  1,3,1,0, 1,0,    5,-14,-15,1);
    vecs[14] = mk(0,0,  0,3,0,1, 0,1,    5,-14,-15,1);
    vecs[15] = mk(0,1,  1,3,1,0, 0,1,    5,-14,-15,1);
    vecs[16] = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[17] = mk(0,1,  3,2,0,0, 0,0,    3,-15,-16,0);
    vecs[18] = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[19] = mk(0,1,  9,3,0,0, 0,0,    9,-16,-16,0);
    vecs[20] = mk(1,1,  4,1,1,0, 1,0,    4,-16,-15,0);
    vecs[21] = mk(0,0,  0,3,0,1, 0,1,    4,-16,-15,0);
    vecs[22] = mk(1,0,  0,3,0,0, 0,0,65535,  0,  0,0);
    vecs[23] = mk(0,0,  0,3,1,0, 1,0,65535,  0,  0,0);
    vecs[24] = mk(0,0,  0,3,0,1, 0,1,65535,  0,  0,0);

    rst_n = 1'b0;
    drive(0,0,0,3,0,0);
    tick(); tick();
    check_outs("reset", 0, 1, 65535, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].st, vecs[i].cv, vecs[i].sad, vecs[i].dir, vecs[i].dn, vecs[i].rdy);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_rdyi, vecs[i].e_sad,
                 vecs[i].e_mx, vecs[i].e_my, vecs[i].e_err);
    end
    drive(0,0,0,3,0,0);
    tick();

    // Full 33x33 snake scan, column-wise, minimum 7 at (16,20).
    drive(1,0,0,3,0,0);
    tick();
    for (int x = 0; x <= 32; x++) begin
      for (int k = 0; k <= 32; k++) begin
        int y;
        int d;
        int s;
        y = (x % 2 == 0) ? k : 32 - k;
        if (x == 0 && k == 0)  d = 3;
        else if (k == 0)       d = 2;
        else if (x % 2 == 0)   d = 1;
        else                   d = 0;
        s = (x == 16 && y == 20) ? 7 : 1000 + ((x * 7 + y * 3) % 50);
        drive(0, 1, s, d, (x == 32 && k == 32) ? 1 : 0, 0);
        tick();
      end
    end
    drive(0,0,0,3,0,0);
    check_outs("snake", 1, 0, 7, 0, 4, 0);

    // HOLD stall: five cycles with readyo low, noise on other inputs.
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, 2, 1, 1, 0);
      tick();
      check_outs($sformatf("stall%0d", c), 1, 0, 7, 0, 4, 0);
    end
    drive(0,0,0,3,0,1);
    tick();
    check_outs("release", 0, 1, 7, 0, 4, 0);
    drive(0,0,0,3,0,0);
    tick();

    // Reset mid-SCAN after 10 candidates.
    drive(1,0,0,3,0,0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 50 - i, (i == 0) ? 2 : 1, 0, 0);
      tick();
    end
    check_outs("pre_rst", 0, 0, 41, -15, -7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 1, 65535, 0, 0, 0);
    drive(0,0,0,3,0,0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 1, 3, 1, 1);
      tick();
      check_outs($sformatf("post_rst%0d", c), 0, 1, 65535, 0, 0, 0);
    end
    drive(1,0,0,3,0,0);
    tick();
    drive(0,0,0,3,1,0);
    tick();
    check_outs("zero_cand", 1, 0, 65535, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/me_mv_tracker.md
ME_MV_TRACKER -- requirements
Module: me_mv_tracker

Interface
REQ-001 SHALL have parameter MACRO_DIM, default 16, macroblock edge in pixels.
REQ-002 SHALL have parameter SEARCH_DIM, default 48, search-window edge in pixels; RANGE = SEARCH_DIM-MACRO_DIM (32).
REQ-003 SHALL have parameter SAD_W, default 16, SAD width in bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begin a new macroblock search.
REQ-007 SHALL have port readyi, output, 1, high only in IDLE.
REQ-008 SHALL have port cand_valid, input, 1, one candidate SAD is present this cycle.
REQ-009 SHALL have port cand_sad, input, SAD_W, candidate SAD.
REQ-010 SHALL have port cand_dir, input, 2, step applied before the candidate: 0 y-1, 1 y+1, 2 x+1, 3 no move.
REQ-011 SHALL have port done, input, 1, last candidate delivered.
REQ-012 SHALL have ports valido (output, 1) and readyo (input, 1), result handshake.
REQ-013 SHALL have ports best_sad (output, SAD_W), mv_x and mv_y (output, 6, signed), err (output, 1).

Function
REQ-014 SHALL implement states IDLE, SCAN, HOLD; IDLE->SCAN on start; SCAN->HOLD on done; HOLD->IDLE on valido&&readyo.
REQ-015 SHALL, on entering SCAN, clear position (x,y) to (0,0), candidate count to 0, err to 0, and best_sad to all-ones.
REQ-016 SHALL, per SCAN cycle with cand_valid, apply cand_dir to (x,y), then evaluate the candidate at the new position.
REQ-017 SHALL hold the position, set err sticky, and still evaluate the candidate if a step would leave 0..RANGE.
REQ-018 SHALL replace best_sad/best position when the candidate is the first of the search or cand_sad < best_sad, strictly; ties keep the earlier position.
REQ-019 SHALL update best registers on the clock edge sampling cand_valid, for one-cycle latency.
REQ-020 SHALL include a candidate that arrives in the same cycle as done before entering HOLD.
REQ-021 SHALL assert valido the cycle after done is sampled and hold valido, best_sad, mv_x, mv_y, and err stable until readyo.
REQ-022 SHALL output mv_x = best_x - RANGE/2 and mv_y = best_y - RANGE/2, two's complement in the range -16..+16.
REQ-023 SHALL output best_sad all-ones and mv_x = mv_y = 0 if zero candidates are received.
REQ-024 SHALL ignore cand_valid and done in IDLE and HOLD, and ignore start in HOLD.
REQ-025 SHALL restart per REQ-015 on start during SCAN, discarding partial results, unless done is also high, in which case done wins.
REQ-026 SHALL saturate the candidate count at (RANGE+1)^2; the count is internal only.

Reset
REQ-027 SHALL, on rst_n low at any time, force IDLE, readyi=1, valido=0, best_sad all-ones, mv_x=mv_y=0, err=0, and position=(0,0).
REQ-028 SHALL abort any search in progress on reset mid-SCAN or mid-HOLD, with no result presented after release.

Structure
REQ-029 SHALL take MACRO_DIM, SEARCH_DIM, the cand_dir enumeration, and the state enumeration from shared package me_pkg.
REQ-030 SHALL place the x/y position counters with bounds check in one sub-module, me_pos_counter.

Verification
REQ-031 SHALL test a single candidate, sad 100, dir 3, then done: valido=1 the next cycle, best_sad=100, mv=(-16,-16), err=0.
REQ-032 SHALL test the tie rule, sads 50 (dir 3) and 50 (dir 1): best_sad=50, mv=(-16,-16).
REQ-033 SHALL test a full 33x33 snake scan with the minimum 7 placed at x=16, y=20: mv=(0,+4), err=0.
REQ-034 SHALL test dir 0 from y=0: err=1, position held, and the candidate still compared.
REQ-035 SHALL test readyo low for 5 cycles in HOLD: outputs stable, then valido=1 with readyo=1 returns the block to IDLE and sets readyi=1.
REQ-036 SHALL test rst_n low mid-SCAN after 10 candidates: reset values per REQ-027 with no valido afterwards, and done with zero candidates gives all-ones and mv 0.
